// File: rtl/cdb_arbiter_if.sv
// EBR branch broadcast bus: one tag per cycle, either killed or cleaned.
interface brb_itf #(
    parameter int BR_MASK_W = 4
);
    localparam int TAG_W = (BR_MASK_W > 1) ? $clog2(BR_MASK_W) : 1;

    logic             broadcast;
    logic [TAG_W-1:0] tag;
    logic             kill;
    logic             clean;

    modport req (input broadcast, input tag, input kill, input clean);
    modport drv (output broadcast, output tag, output kill, output clean);
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with a registered broadcast that honours
// EBR kill/clean both at grant time and during the broadcast cycle.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6,
    parameter int BR_MASK_W = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    brb_itf.req                                 brif,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][31:0]            req_result,
    input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ-1:0][PREG_W-1:0]      req_pd,
    input  logic [NUM_REQ-1:0]                  req_rd_we,
    input  logic [NUM_REQ-1:0][BR_MASK_W-1:0]   req_br_mask,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                cdb_valid,
    output logic [31:0]                         cdb_result,
    output logic [ROB_IDX_W-1:0]                cdb_rob_idx,
    output logic [PREG_W-1:0]                   cdb_pd,
    output logic                                cdb_rd_we,
    output logic [BR_MASK_W-1:0]                cdb_br_mask
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic                  kill_now;
    logic                  clean_now;
    logic [NUM_REQ-1:0]    eligible;
    logic                  grant;
    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;

    logic [PTR_W-1:0]      rr_ptr_q,      rr_ptr_d;
    logic                  cdb_valid_q,   cdb_valid_d;
    logic [31:0]           cdb_result_q,  cdb_result_d;
    logic [ROB_IDX_W-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
    logic [PREG_W-1:0]     cdb_pd_q,      cdb_pd_d;
    logic                  cdb_rd_we_q,   cdb_rd_we_d;
    logic [BR_MASK_W-1:0]  cdb_br_mask_q, cdb_br_mask_d;

    assign kill_now  = brif.broadcast & brif.kill;
    assign clean_now = brif.broadcast & brif.clean;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & ~(kill_now & req_br_mask[i][brif.tag]);
        end
    end

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (eligible[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    assign grant = grant_found & ~rst;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        cdb_valid_d   = grant;
        cdb_result_d  = cdb_result_q;
        cdb_rob_idx_d = cdb_rob_idx_q;
        cdb_pd_d      = cdb_pd_q;
        cdb_rd_we_d   = cdb_rd_we_q;
        cdb_br_mask_d = cdb_br_mask_q;
        if (grant) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PTR_W'(1);
            end
            cdb_result_d  = req_result[grant_idx];
            cdb_rob_idx_d = req_rob_idx[grant_idx];
            cdb_pd_d      = req_pd[grant_idx];
            cdb_rd_we_d   = req_rd_we[grant_idx];
            cdb_br_mask_d = req_br_mask[grant_idx];
            if (clean_now) begin
                cdb_br_mask_d[brif.tag] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            cdb_valid_q   <= 1'b0;
            cdb_result_q  <= '0;
            cdb_rob_idx_q <= '0;
            cdb_pd_q      <= '0;
            cdb_rd_we_q   <= 1'b0;
            cdb_br_mask_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_result_q  <= cdb_result_d;
            cdb_rob_idx_q <= cdb_rob_idx_d;
            cdb_pd_q      <= cdb_pd_d;
            cdb_rd_we_q   <= cdb_rd_we_d;
            cdb_br_mask_q <= cdb_br_mask_d;
        end
    end

    // Branch events act on the live broadcast so consumers never see stale state.
    always_comb begin
        cdb_br_mask = cdb_br_mask_q;
        if (clean_now) begin
            cdb_br_mask[brif.tag] = 1'b0;
        end
    end

    assign cdb_valid   = cdb_valid_q & ~(kill_now & cdb_br_mask_q[brif.tag]);
    assign cdb_result  = cdb_result_q;
    assign cdb_rob_idx = cdb_rob_idx_q;
    assign cdb_pd      = cdb_pd_q;
    assign cdb_rd_we   = cdb_rd_we_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, fairness, single unit, and EBR
// kill/clean on both requests and the live broadcast.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_result;
    logic [3:0][4:0]  req_rob_idx;
    logic [3:0][5:0]  req_pd;
    logic [3:0]       req_rd_we;
    logic [3:0][3:0]  req_br_mask;
    logic [3:0]       req_ready;
    logic             cdb_valid;
    logic [31:0]      cdb_result;
    logic [4:0]       cdb_rob_idx;
    logic [5:0]       cdb_pd;
    logic             cdb_rd_we;
    logic [3:0]       cdb_br_mask;

    int total_cnt = 0;
    int pass_cnt  = 0;

    brb_itf #(.BR_MASK_W(4)) brif ();

    cdb_arbiter #(
        .NUM_REQ(4), .ROB_IDX_W(5), .PREG_W(6), .BR_MASK_W(4)
    ) dut (
        .clk(clk), .rst(rst), .brif(brif),
        .req_valid(req_valid), .req_result(req_result), .req_rob_idx(req_rob_idx),
        .req_pd(req_pd), .req_rd_we(req_rd_we), .req_br_mask(req_br_mask),
        .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
        .cdb_rob_idx(cdb_rob_idx), .cdb_pd(cdb_pd), .cdb_rd_we(cdb_rd_we),
        .cdb_br_mask(cdb_br_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_brb(input logic b, input logic [1:0] t, input logic k, input logic c);
        brif.broadcast = b;
        brif.tag       = t;
        brif.kill      = k;
        brif.clean     = c;
    endtask

    logic [31:0] exp_res;
    int g;

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_rd_we = 4'b1111;
        set_brb(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            req_result[i]  = 32'h100 + 32'(i);
            req_rob_idx[i] = 5'(i);
            req_pd[i]      = 6'(i + 20);
            req_br_mask[i] = 4'b0000;
        end

        // Reset with every unit requesting.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   req_ready,   4'b0000);
        check("rst_valid",   cdb_valid,   1'b0);
        check("rst_result",  cdb_result,  32'h0);
        check("rst_rob",     cdb_rob_idx, 5'd0);
        check("rst_pd",      cdb_pd,      6'd0);
        check("rst_rd_we",   cdb_rd_we,   1'b0);
        check("rst_br_mask", cdb_br_mask, 4'b0000);
        rst = 1'b0;
        #1;
        check("first_grant", req_ready, 4'b0001);

        // Fairness: all units continuously valid, new payload after each grant.
        for (int c = 0; c < 8; c++) begin
            g = c % 4;
            check("fair_ready", req_ready, 4'(1) << g);
            exp_res = req_result[g];
            tick();
            check("fair_valid",  cdb_valid,  1'b1);
            check("fair_result", cdb_result, exp_res);
            req_result[g] = req_result[g] + 32'h10;
            #1;
        end

        // Single unit 2.
        req_valid      = 4'b0100;
        req_result[2]  = 32'hDEADBEEF;
        req_rob_idx[2] = 5'd7;
        req_pd[2]      = 6'd13;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick();
        check("single_valid",  cdb_valid,   1'b1);
        check("single_result", cdb_result,  32'hDEADBEEF);
        check("single_rob",    cdb_rob_idx, 5'd7);
        check("single_pd",     cdb_pd,      6'd13);
        check("single_rd_we",  cdb_rd_we,   1'b1);
        req_valid = 4'b1111;
        #1;
        check("ptr_after_2", req_ready, 4'b1000);
        tick();

        // Kill on request: pointer is 0, unit 0 killed, unit 1 wins.
        req_valid      = 4'b0011;
        req_br_mask[0] = 4'b0010;
        req_rob_idx[0] = 5'd8;
        req_rob_idx[1] = 5'd9;
        set_brb(1'b1, 2'd1, 1'b1, 1'b0);
        #1;
        check("kill_req_ready", req_ready, 4'b0010);
        check("kill_miss_cdb",  cdb_valid, 1'b1);
        tick();
        set_brb(1'b0, 2'd0, 1'b0, 1'b0);
        req_br_mask[0] = 4'b0000;
        check("kill_req_valid", cdb_valid,   1'b1);
        check("kill_req_rob",   cdb_rob_idx, 5'd9);

        // Kill on broadcast: pointer is 2.
        req_valid      = 4'b0100;
        req_br_mask[2] = 4'b1000;
        req_rob_idx[2] = 5'd12;
        #1;
        check("kb_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        set_brb(1'b1, 2'd2, 1'b1, 1'b0);
        #1;
        check("kb_miss_valid", cdb_valid, 1'b1);
        brif.tag = 2'd3;
        #1;
        check("kb_hit_valid", cdb_valid, 1'b0);
        tick();
        set_brb(1'b0, 2'd0, 1'b0, 1'b0);
        check("idle_valid", cdb_valid,   1'b0);
        check("idle_hold",  cdb_rob_idx, 5'd12);

        // Clean at load: pointer is 3.
        req_valid      = 4'b1000;
        req_br_mask[3] = 4'b0011;
        req_rob_idx[3] = 5'd5;
        set_brb(1'b1, 2'd0, 1'b0, 1'b1);
        #1;
        check("clean_ready", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000;
        set_brb(1'b0, 2'd0, 1'b0, 1'b0);
        #1;
        check("clean_mask",  cdb_br_mask, 4'b0010);
        check("clean_valid", cdb_valid,   1'b1);
        check("clean_rob",   cdb_rob_idx, 5'd5);
        set_brb(1'b1, 2'd1, 1'b0, 1'b1);
        #1;
        check("clean_live_mask", cdb_br_mask, 4'b0000);

        // Kill and clean on the same tag: kill wins, nothing granted.
        req_valid      = 4'b0001;
        req_br_mask[0] = 4'b0100;
        set_brb(1'b1, 2'd2, 1'b1, 1'b1);
        #1;
        check("kill_clean_ready", req_ready, 4'b0000);
        tick();
        set_brb(1'b0, 2'd0, 1'b0, 1'b0);
        req_br_mask[0] = 4'b0000;
        check("kill_clean_valid", cdb_valid, 1'b0);

        // Reset mid-operation: pointer 0, grant unit 1, then reset.
        req_valid = 4'b0010;
        #1;
        check("mid_ready", req_ready, 4'b0010);
        tick();
        check("mid_valid", cdb_valid, 1'b1);
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid_rst_ready", req_ready, 4'b0000);
        tick();
        check("mid_rst_valid",  cdb_valid,  1'b0);
        check("mid_rst_result", cdb_result, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_ptr", req_ready, 4'b0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
